pci_target_mem: RTL and testbench

//  PCI-style bus target (responder) backed by a small word memory; the responding end of the

---
 rtl/pci_target_mem.sv | 138 +++++++++++++
 tb/tb_pci_target_mem.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pci_target_mem.sv
// PCI-style bus target backed by a small word memory: claims FRAME/IRDY transactions in its window.
// Latency: DEVSEL/TRDY one cycle after address phase on writes; one turnaround cycle before read data.
// Backpressure: initiator wait states (IRDY high) stall idx and hold AD; target never inserts waits.
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_DEPTH = 10,
  parameter int          IDX_W     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  inout  wire         DEVSEL,
  inout  wire         TRDY,
  output logic [7:0]  hit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSY, S_W_DATA, S_R_TURN, S_R_DATA, S_BACKOFF
  } state_t;

  localparam logic [3:0]  CMD_MEM_WR = 4'b0111;
  localparam logic [3:0]  CMD_MEM_RD = 4'b0110;
  // 33-bit window bounds so a window touching the top of the address space cannot overflow
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MEM_DEPTH - 1);

  state_t            state, state_n;
  logic              frame_q;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       mem [MEM_DEPTH];

  logic              addr_phase, in_win, hit, mem_we, idx_adv;
  logic [31:0]       ad_off;
  logic [IDX_W-1:0]  idx_dec;
  logic              ad_oe, devsel_oe, devsel_val, trdy_val;

  // Burst index advance; running off the top of the window continues at word 0
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_TOP) ? '0 : x + 1'b1;
  endfunction

  assign addr_phase = (state == S_IDLE) && !FRAME && frame_q;
  assign in_win     = ({1'b0, AD} >= WIN_LO) && ({1'b0, AD} < WIN_HI);
  assign ad_off     = AD - BASE_ADDR;
  assign idx_dec    = IDX_W'(ad_off >> 2);

  // Next-state decode and per-edge actions (claim, memory write, index advance)
  always_comb begin
    state_n = state;
    hit     = 1'b0;
    mem_we  = 1'b0;
    idx_adv = 1'b0;
    case (state)
      S_IDLE: begin
        if (addr_phase) begin
          if (in_win && CBE == CMD_MEM_WR) begin
            state_n = S_W_DATA;
            hit     = 1'b1;
          end else if (in_win && CBE == CMD_MEM_RD) begin
            state_n = S_R_TURN;
            hit     = 1'b1;
          end else begin
            state_n = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (FRAME && IRDY) state_n = S_IDLE;
      end
      S_W_DATA: begin
        // TRDY is always asserted here, so IRDY alone qualifies a transfer
        if (!IRDY) begin
          mem_we  = 1'b1;
          idx_adv = 1'b1;
        end
        // FRAME high means either last data phase or an abort (IRDY also high)
        if (FRAME) state_n = S_BACKOFF;
      end
      S_R_TURN: begin
        state_n = (FRAME && IRDY) ? S_BACKOFF : S_R_DATA;
      end
      S_R_DATA: begin
        if (!IRDY) idx_adv = 1'b1;
        if (FRAME) state_n = S_BACKOFF;
      end
      S_BACKOFF: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bus drive enables and levels depend on registered state only
  always_comb begin
    ad_oe      = (state == S_R_DATA);
    devsel_oe  = (state == S_W_DATA) || (state == S_R_TURN) ||
                 (state == S_R_DATA) || (state == S_BACKOFF);
    devsel_val = (state == S_BACKOFF);
    trdy_val   = (state == S_R_TURN) || (state == S_BACKOFF);
  end

  // State, FRAME history, burst index and claim counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      frame_q <= 1'b1;
      idx     <= '0;
      hit_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      frame_q <= FRAME;
      if (hit) begin
        idx     <= idx_dec;
        hit_cnt <= hit_cnt + 8'd1;
      end else if (idx_adv) begin
        idx <= wrap_inc(idx);
      end
    end
  end

  // Byte-enabled memory write; contents intentionally survive reset
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!CBE[b]) mem[idx][8*b +: 8] <= AD[8*b +: 8];
      end
    end
  end

  assign AD     = ad_oe     ? mem[idx]   : 'z;
  assign DEVSEL = devsel_oe ? devsel_val : 1'bz;
  assign TRDY   = devsel_oe ? trdy_val   : 1'bz;

endmodule

// File: tb/tb_pci_target_mem.sv
// Bench for pci_target_mem: table of per-cycle bus vectors with expected target response.
// Latency: each row describes one bus cycle; outputs compared mid-cycle (falling edge).
// Backpressure: exercises initiator wait states, aborts, misses and reset mid-burst.
module tb_pci_target_mem;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FRAME;
  logic        IRDY;
  logic [3:0]  CBE;
  tri1  [31:0] AD;
  tri1         DEVSEL;
  tri1         TRDY;
  logic [7:0]  hit_cnt;

  logic        ad_en;
  logic [31:0] ad_val;

  assign AD = ad_en ? ad_val : 'z;

  always #5 CLK = ~CLK;

  pci_target_mem #(
    .BASE_ADDR(32'h0000_0000),
    .MEM_DEPTH(10),
    .IDX_W    (4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .FRAME  (FRAME),
    .IRDY   (IRDY),
    .CBE    (CBE),
    .AD     (AD),
    .DEVSEL (DEVSEL),
    .TRDY   (TRDY),
    .hit_cnt(hit_cnt)
  );

  localparam logic [3:0]  MW = 4'b0111;
  localparam logic [3:0]  MR = 4'b0110;
  localparam logic [3:0]  NB = 4'b1111;
  localparam logic [31:0] ZV = 32'hFFFF_FFFF;  // released AD reads as pulled-up
  localparam logic [31:0] M1 = 32'hA5A5_0001;
  localparam logic [31:0] M3 = 32'h5A5A_0003;
  localparam logic [31:0] W9 = 32'hCAFE_0009;
  localparam logic [31:0] W0 = 32'hCAFE_0000;
  localparam logic [31:0] WB = 32'hCAFE_0001;
  localparam logic [31:0] M2 = 32'hDE22_BE44;

  typedef struct {
    logic        frame;
    logic        irdy;
    logic [3:0]  cbe;
    logic        ad_en;
    logic [31:0] ad_val;
    logic        exp_devsel;
    logic        exp_trdy;
    logic        chk_ad;
    logic [31:0] exp_ad;
    logic [7:0]  exp_hit;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void r(input logic f, input logic i, input logic [3:0] c,
                            input logic ae, input logic [31:0] av,
                            input logic ed, input logic et,
                            input logic ca, input logic [31:0] ea, input logic [7:0] eh);
    vec_t v;
    v.frame = f; v.irdy = i; v.cbe = c; v.ad_en = ae; v.ad_val = av;
    v.exp_devsel = ed; v.exp_trdy = et; v.chk_ad = ca; v.exp_ad = ea; v.exp_hit = eh;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Drive one bus cycle, queue its expectation, compare mid-cycle, then advance past the edge
  task automatic apply(input vec_t v, input int row);
    vec_t e;
    FRAME  = v.frame;
    IRDY   = v.irdy;
    CBE    = v.cbe;
    ad_en  = v.ad_en;
    ad_val = v.ad_val;
    sb.push_back(v);
    @(negedge CLK);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard row %0d: queue empty", row);
    end else begin
      e = sb.pop_front();
      check("devsel", row, {31'd0, DEVSEL}, {31'd0, e.exp_devsel});
      check("trdy", row, {31'd0, TRDY}, {31'd0, e.exp_trdy});
      check("hit_cnt", row, {24'd0, hit_cnt}, {24'd0, e.exp_hit});
      if (e.chk_ad) check("ad", row, AD, e.exp_ad);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // idle and single write of DEADBEEF to word 2
    r(1,1,NB,0,0,              1,1,1,ZV,0);
    r(0,1,MW,1,32'h08,         1,1,0,0,0);
    r(1,0,4'b0000,1,32'hDEADBEEF,0,0,0,0,1);
    r(1,1,NB,0,0,              1,1,1,ZV,1);
    // back-to-back byte-enabled write to word 2
    r(0,1,MW,1,32'h08,         1,1,0,0,1);
    r(1,0,4'b1010,1,32'h11223344,0,0,0,0,2);
    r(1,1,NB,0,0,              1,1,1,ZV,2);
    r(1,1,NB,0,0,              1,1,1,ZV,2);
    // word 1, then word 3 with an initiator wait state carrying junk data
    r(0,1,MW,1,32'h04,         1,1,0,0,2);
    r(1,0,4'b0000,1,M1,        0,0,0,0,3);
    r(1,1,NB,0,0,              1,1,1,ZV,3);
    r(0,1,MW,1,32'h0C,         1,1,0,0,3);
    r(0,1,4'b0000,1,32'hFFFF0000,0,0,0,0,4);
    r(1,0,4'b0000,1,M3,        0,0,0,0,4);
    r(1,1,NB,0,0,              1,1,1,ZV,4);
    r(1,1,NB,0,0,              1,1,1,ZV,4);
    // 3-word read burst from 0x04 with a wait on the second data phase
    r(0,1,MR,1,32'h04,         1,1,0,0,4);
    r(0,0,4'b0000,0,0,         0,1,1,ZV,5);
    r(0,0,4'b0000,0,0,         0,0,1,M1,5);
    r(0,1,4'b0000,0,0,         0,0,1,M2,5);
    r(0,0,4'b0000,0,0,         0,0,1,M2,5);
    r(1,0,4'b0000,0,0,         0,0,1,M3,5);
    r(1,1,NB,0,0,              1,1,1,ZV,5);
    // write burst wrapping from word 9 to words 0 and 1
    r(0,1,MW,1,32'h24,         1,1,0,0,5);
    r(0,0,4'b0000,1,W9,        0,0,0,0,6);
    r(0,0,4'b0000,1,W0,        0,0,0,0,6);
    r(1,0,4'b0000,1,WB,        0,0,0,0,6);
    r(1,1,NB,0,0,              1,1,1,ZV,6);
    // read back across the wrap, plus untouched word 2
    r(0,1,MR,1,32'h24,         1,1,0,0,6);
    r(0,0,4'b0000,0,0,         0,1,1,ZV,7);
    r(0,0,4'b0000,0,0,         0,0,1,W9,7);
    r(0,0,4'b0000,0,0,         0,0,1,W0,7);
    r(0,0,4'b0000,0,0,         0,0,1,WB,7);
    r(1,0,4'b0000,0,0,         0,0,1,M2,7);
    r(1,1,NB,0,0,              1,1,1,ZV,7);
    // misses: out of window, first byte past window, unsupported command
    r(0,1,MW,1,32'h100,        1,1,0,0,7);
    r(1,0,4'b0000,1,32'h12345678,1,1,0,0,7);
    r(1,1,NB,0,0,              1,1,1,ZV,7);
    r(0,1,MR,1,32'h28,         1,1,0,0,7);
    r(0,0,4'b0000,0,0,         1,1,1,ZV,7);
    r(1,0,4'b0000,0,0,         1,1,1,ZV,7);
    r(1,1,NB,0,0,              1,1,1,ZV,7);
    r(0,1,4'b0010,1,32'h00,    1,1,0,0,7);
    r(1,0,4'b0000,0,0,         1,1,1,ZV,7);
    r(1,1,NB,0,0,              1,1,1,ZV,7);
    // initiator abort during turnaround
    r(0,1,MR,1,32'h00,         1,1,0,0,7);
    r(1,1,NB,0,0,              0,1,1,ZV,8);
    r(1,1,NB,0,0,              1,1,1,ZV,8);
    r(1,1,NB,0,0,              1,1,1,ZV,8);
    // last word of window with AD[1:0] set
    r(0,1,MR,1,32'h27,         1,1,0,0,8);
    r(0,0,4'b0000,0,0,         0,1,1,ZV,9);
    r(1,0,4'b0000,0,0,         0,0,1,W9,9);
    r(1,1,NB,0,0,              1,1,1,ZV,9);

    RST = 1'b0; FRAME = 1'b1; IRDY = 1'b1; CBE = NB; ad_en = 1'b0; ad_val = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_devsel", -1, {31'd0, DEVSEL}, 32'd1);
    check("rst_trdy", -1, {31'd0, TRDY}, 32'd1);
    check("rst_ad", -1, AD, ZV);
    check("rst_hit_cnt", -1, {24'd0, hit_cnt}, 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    // reset asserted between edges while the target drives read data
    vecs.delete();
    r(0,1,MR,1,32'h08,         1,1,0,0,9);
    r(0,0,4'b0000,0,0,         0,1,1,ZV,10);
    r(0,0,4'b0000,0,0,         0,0,1,M2,10);
    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], 100 + k);
    #2;
    check("pre_rst_ad", 200, AD, M3);
    RST = 1'b0; FRAME = 1'b1; IRDY = 1'b1; CBE = NB;
    #1;
    check("midrst_devsel", 201, {31'd0, DEVSEL}, 32'd1);
    check("midrst_trdy", 201, {31'd0, TRDY}, 32'd1);
    check("midrst_ad", 201, AD, ZV);
    check("midrst_hit_cnt", 201, {24'd0, hit_cnt}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // memory survives reset
    vecs.delete();
    r(1,1,NB,0,0,              1,1,1,ZV,0);
    r(0,1,MR,1,32'h08,         1,1,0,0,0);
    r(0,0,4'b0000,0,0,         0,1,1,ZV,1);
    r(1,0,4'b0000,0,0,         0,0,1,M2,1);
    r(1,1,NB,0,0,              1,1,1,ZV,1);
    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], 300 + k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
